// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
// Optional build macro used across this slice: REGFILE_ZERO_REG_EN (hardwired zero register).
package regfile_scoreboard_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;
  localparam int DEFAULT_REG_WIDTH = 4;
  localparam int DEFAULT_NUM_READ  = 2;

  function automatic int regSize(input int regWidth);
    return 1 << regWidth;
  endfunction

  // Bit offset of a port's field inside a packed multi-port bus.
  function automatic int portOffset(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the pipeline stages and the register file / scoreboard.
// The master side drives writeback, reserve and read addresses; the slave is the register file.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int NUM_READ  = DEFAULT_NUM_READ
);
  localparam int REG_SIZE = regSize(REG_WIDTH);

  logic                          i_lock;
  logic                          i_we;
  logic [REG_WIDTH-1:0]          i_dr;
  logic [BIT_WIDTH-1:0]          i_din;
  logic                          i_rsv;
  logic [REG_WIDTH-1:0]          i_rsvDr;
  logic [NUM_READ*REG_WIDTH-1:0] i_sr;
  logic [NUM_READ*BIT_WIDTH-1:0] o_srOut;
  logic [NUM_READ-1:0]           o_srBusy;
  logic [REG_SIZE-1:0]           o_busyVec;

  modport master (
    output i_lock, i_we, i_dr, i_din, i_rsv, i_rsvDr, i_sr,
    input  o_srOut, o_srBusy, o_busyVec
  );

  modport slave (
    input  i_lock, i_we, i_dr, i_din, i_rsv, i_rsvDr, i_sr,
    output o_srOut, o_srBusy, o_busyVec
  );

endinterface

// File: rtl/regfile_busy_table.sv
// Per-register busy scoreboard: reserve sets, writeback clears, a same-edge reserve wins.
// With REGFILE_ZERO_REG_EN defined, entry 0 can never become busy.
module regfile_busy_table
  import regfile_scoreboard_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int REG_SIZE  = regSize(DEFAULT_REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_lock,
  input  logic                 i_we,
  input  logic [REG_WIDTH-1:0] i_dr,
  input  logic                 i_rsv,
  input  logic [REG_WIDTH-1:0] i_rsvDr,
  output logic [REG_SIZE-1:0]  o_busyVec
);

  logic [REG_SIZE-1:0] r_busyVec;

  // The set is written after the clear so a new producer on the same register stays busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busyVec <= '0;
    end else if (i_lock) begin
      if (i_we)  r_busyVec[i_dr]    <= 1'b0;
      if (i_rsv) r_busyVec[i_rsvDr] <= 1'b1;
`ifdef REGFILE_ZERO_REG_EN
      r_busyVec[0] <= 1'b0;
`endif
    end
  end

  assign o_busyVec = r_busyVec;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, write forwarding and a busy scoreboard.
// Build macro REGFILE_ZERO_REG_EN makes register 0 a hardwired zero.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int NUM_READ  = DEFAULT_NUM_READ
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int REG_SIZE = regSize(REG_WIDTH);

  logic [BIT_WIDTH-1:0]          r_regs [REG_SIZE];
  logic [REG_SIZE-1:0]           w_busyVec;
  logic [REG_WIDTH-1:0]          w_addr [NUM_READ];
  logic                          w_wbHit [NUM_READ];
  logic                          w_fwd [NUM_READ];
  logic [NUM_READ*BIT_WIDTH-1:0] w_srOut;
  logic [NUM_READ-1:0]           w_srBusy;
  logic                          w_writeEn;

`ifdef REGFILE_ZERO_REG_EN
  assign w_writeEn = bus.i_lock && bus.i_we && (bus.i_dr != '0);
`else
  assign w_writeEn = bus.i_lock && bus.i_we;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < REG_SIZE; k++) r_regs[k] <= '0;
    end else if (w_writeEn) begin
      r_regs[bus.i_dr] <= bus.i_din;
    end
  end

  // A writeback hit always clears the busy flag; forwarding is additionally blocked for a hardwired zero.
  for (genvar g = 0; g < NUM_READ; g++) begin : gPort
    assign w_addr[g]  = bus.i_sr[portOffset(g, REG_WIDTH) +: REG_WIDTH];
    assign w_wbHit[g] = bus.i_we && (bus.i_dr == w_addr[g]);
`ifdef REGFILE_ZERO_REG_EN
    assign w_fwd[g]   = w_wbHit[g] && (w_addr[g] != '0);
`else
    assign w_fwd[g]   = w_wbHit[g];
`endif
  end

  always_comb begin
    w_srOut  = '0;
    w_srBusy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      w_srOut[portOffset(i, BIT_WIDTH) +: BIT_WIDTH] = w_fwd[i] ? bus.i_din : r_regs[w_addr[i]];
      w_srBusy[i] = w_busyVec[w_addr[i]] & ~w_wbHit[i];
    end
  end

  regfile_busy_table #(
    .REG_WIDTH (REG_WIDTH),
    .REG_SIZE  (REG_SIZE)
  ) uBusyTable (
    .clk       (clk),
    .rst       (rst),
    .i_lock    (bus.i_lock),
    .i_we      (bus.i_we),
    .i_dr      (bus.i_dr),
    .i_rsv     (bus.i_rsv),
    .i_rsvDr   (bus.i_rsvDr),
    .o_busyVec (w_busyVec)
  );

  assign bus.o_srOut   = w_srOut;
  assign bus.o_srBusy  = w_srBusy;
  assign bus.o_busyVec = w_busyVec;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: vector table with a queue of expected outputs,
// plus hand-written reset sequences. Expectations follow REGFILE_ZERO_REG_EN when it is defined.
module tb_regfile_scoreboard;

  localparam int BW = 32;
  localparam int RW = 4;
  localparam int NR = 2;
  localparam int NV = 20;

  typedef struct {
    logic          lock;
    logic          we;
    logic [RW-1:0] dr;
    logic [BW-1:0] din;
    logic          rsv;
    logic [RW-1:0] rsvDr;
    logic [RW-1:0] sr0;
    logic [RW-1:0] sr1;
    logic [BW-1:0] expOut0;
    logic [BW-1:0] expOut1;
    logic [1:0]    expBusy;
    logic [15:0]   expVec;
  } vec_t;

  typedef struct {
    logic [BW-1:0] out0;
    logic [BW-1:0] out1;
    logic [1:0]    busy;
    logic [15:0]   vec;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  vec_t vecs [NV];
  exp_t expQ [$];

  regfile_scoreboard_if #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_READ(NR)) busIf ();

  regfile_scoreboard #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_READ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic lock, input logic we, input logic [RW-1:0] dr, input logic [BW-1:0] din,
                             input logic rsv, input logic [RW-1:0] rsvDr, input logic [RW-1:0] sr0, input logic [RW-1:0] sr1);
    busIf.i_lock  = lock;
    busIf.i_we    = we;
    busIf.i_dr    = dr;
    busIf.i_din   = din;
    busIf.i_rsv   = rsv;
    busIf.i_rsvDr = rsvDr;
    busIf.i_sr    = {sr1, sr0};
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveInputs(v.lock, v.we, v.dr, v.din, v.rsv, v.rsvDr, v.sr0, v.sr1);
    e.out0 = v.expOut0;
    e.out1 = v.expOut1;
    e.busy = v.expBusy;
    e.vec  = v.expVec;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t  e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s queue: got empty, expected an entry", tag);
      return;
    end
    e = expQ.pop_front();
    compareVal({tag, " srout0"}, busIf.o_srOut[BW-1:0], e.out0);
    compareVal({tag, " srout1"}, busIf.o_srOut[2*BW-1:BW], e.out1);
    compareVal({tag, " srbusy"}, {30'd0, busIf.o_srBusy}, {30'd0, e.busy});
    compareVal({tag, " busyvec"}, {16'd0, busIf.o_busyVec}, {16'd0, e.vec});
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // fields: lock we dr din rsv rsvDr sr0 sr1 | out0 out1 busy vec
    vecs[0]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 3, 32'hDEADBEEF, 32'h0, 2'b00, 16'h0000};
    vecs[1]  = '{1, 0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[2]  = '{1, 0, 0, 32'h0,        1, 9, 9, 5, 32'h0, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[3]  = '{1, 0, 0, 32'h0,        0, 0, 9, 9, 32'h0, 32'h0, 2'b11, 16'h0200};
    vecs[4]  = '{1, 0, 0, 32'h0,        0, 0, 9, 5, 32'h0, 32'hDEADBEEF, 2'b01, 16'h0200};
    vecs[5]  = '{1, 1, 9, 32'h1234,     0, 0, 9, 9, 32'h1234, 32'h1234, 2'b00, 16'h0200};
    vecs[6]  = '{1, 0, 0, 32'h0,        0, 0, 9, 5, 32'h1234, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[7]  = '{1, 0, 0, 32'h0,        1, 4, 4, 9, 32'h0, 32'h1234, 2'b00, 16'h0000};
    vecs[8]  = '{1, 1, 4, 32'hCAFE0004, 1, 4, 4, 4, 32'hCAFE0004, 32'hCAFE0004, 2'b00, 16'h0010};
    vecs[9]  = '{1, 0, 0, 32'h0,        0, 0, 4, 2, 32'hCAFE0004, 32'h0, 2'b01, 16'h0010};
    vecs[10] = '{0, 1, 2, 32'hAA,       1, 3, 2, 3, 32'hAA, 32'h0, 2'b00, 16'h0010};
    vecs[11] = '{1, 0, 0, 32'h0,        0, 0, 2, 3, 32'h0, 32'h0, 2'b00, 16'h0010};
    vecs[12] = '{1, 0, 0, 32'h0,        1, 4, 4, 9, 32'hCAFE0004, 32'h1234, 2'b01, 16'h0010};
    vecs[13] = '{1, 1, 4, 32'h55,       0, 0, 4, 4, 32'h55, 32'h55, 2'b00, 16'h0010};
    vecs[14] = '{1, 0, 0, 32'h0,        0, 0, 4, 0, 32'h55, 32'h0, 2'b00, 16'h0000};
`ifdef REGFILE_ZERO_REG_EN
    vecs[15] = '{1, 1, 0, 32'hFF,       1, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[16] = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 16'h0000};
    vecs[17] = '{1, 1, 0, 32'h0,        0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 16'h0000};
`else
    vecs[15] = '{1, 1, 0, 32'hFF,       1, 0, 0, 5, 32'hFF, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[16] = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'hFF, 32'hFF, 2'b11, 16'h0001};
    vecs[17] = '{1, 1, 0, 32'h0,        0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 16'h0001};
`endif
    vecs[18] = '{1, 1, 7, 32'h77,       1, 3, 7, 3, 32'h77, 32'h0, 2'b00, 16'h0000};
    vecs[19] = '{1, 0, 0, 32'h0,        0, 0, 7, 3, 32'h77, 32'h0, 2'b10, 16'h0008};

    // Reset held for two edges with reads pointed at 3 and 7.
    rst = 1'b1;
    driveInputs(1, 0, 0, 32'h0, 0, 0, 3, 7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compareVal("reset srout0", busIf.o_srOut[BW-1:0], 32'h0);
    compareVal("reset srout1", busIf.o_srOut[2*BW-1:BW], 32'h0);
    compareVal("reset srbusy", {30'd0, busIf.o_srBusy}, 32'h0);
    compareVal("reset busyvec", {16'd0, busIf.o_busyVec}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i);
    end

    // Reset in the middle of a cycle while register 3 is reserved: scoreboard clears at once,
    // and the write/reserve presented during reset must be discarded.
    @(posedge clk);
    #1;
    driveInputs(1, 0, 0, 32'h0, 0, 0, 7, 6);
    #1;
    compareVal("pre-reset busyvec", {16'd0, busIf.o_busyVec}, 32'h0008);
    driveInputs(1, 1, 6, 32'h66, 1, 5, 7, 6);
    rst = 1'b1;
    #1;
    compareVal("mid-reset busyvec", {16'd0, busIf.o_busyVec}, 32'h0);
    compareVal("mid-reset srout0", busIf.o_srOut[BW-1:0], 32'h0);
    compareVal("mid-reset fwd srout1", busIf.o_srOut[2*BW-1:BW], 32'h66);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    driveInputs(1, 0, 0, 32'h0, 0, 0, 5, 6);
    #1;
    compareVal("post-reset busyvec", {16'd0, busIf.o_busyVec}, 32'h0);
    compareVal("post-reset reg6", busIf.o_srOut[2*BW-1:BW], 32'h0);

    // First edge after release performs a reserve.
    driveInputs(1, 0, 0, 32'h0, 1, 5, 5, 6);
    @(posedge clk);
    #1;
    driveInputs(1, 0, 0, 32'h0, 0, 0, 5, 6);
    #1;
    compareVal("release reserve srbusy", {30'd0, busIf.o_srBusy}, 32'h1);
    compareVal("release reserve busyvec", {16'd0, busIf.o_busyVec}, 32'h0020);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL queue drain: got %0d entries left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
